semaforo_monitor: RTL and testbench

Passive checker on the output side of the two-way traffic-light controller (`semaforo`). Samples light buses `A`, `B` and button `bt` every clock and detects illegal encodings, conflicting right-of-way, illegal colour sequences and, optionally, wrong phase durations. It latches the first error with a timestamp and counts all violations. Used in benches and as an on-chip sticky status source; it never drives the controller.

---
 rtl/semaforo_pkg.sv | 35 +++
 rtl/semaforo_side_chk.sv | 95 +++++++++
 rtl/semaforo_monitor.sv | 132 +++++++++++++
 tb/tb_semaforo_monitor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared light/error encodings and default phase lengths for the semaforo output monitor.
// Duration checking is enabled by defining SEMAFORO_DUR_CHECK_EN.
package semaforo_pkg;

    typedef enum logic [2:0] {
        GREEN  = 3'b001,
        YELLOW = 3'b010,
        RED    = 3'b100
    } light_e;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        ENC      = 3'd1,
        CONFLICT = 3'd2,
        SEQ_A    = 3'd3,
        SEQ_B    = 3'd4,
        DUR_A    = 3'd5,
        DUR_B    = 3'd6
    } err_code_e;

    localparam logic [7:0] GREEN_CYC_DEF  = 8'd1;
    localparam logic [7:0] YELLOW_CYC_DEF = 8'd3;

    function automatic logic light_legal(input logic [2:0] l);
        return (l == GREEN) || (l == YELLOW) || (l == RED);
    endfunction

    // Only the forward steps G->Y, Y->R and R->G are allowed.
    function automatic logic step_legal(input logic [2:0] p, input logic [2:0] c);
        return ((p == GREEN)  && (c == YELLOW)) ||
               ((p == YELLOW) && (c == RED))    ||
               ((p == RED)    && (c == GREEN));
    endfunction

endpackage

// File: rtl/semaforo_side_chk.sv
// Per-side checker: holds the previous light value and, when SEMAFORO_DUR_CHECK_EN is
// defined, the run counter used to validate green/yellow phase lengths.
module semaforo_side_chk
    import semaforo_pkg::*;
#(
    parameter logic [7:0] GREEN_CYC  = GREEN_CYC_DEF,
    parameter logic [7:0] YELLOW_CYC = YELLOW_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    input  logic       prev_valid,
    output logic       enc_bad,
    output logic       seq_bad,
    output logic       dur_bad,
    output logic       non_red
);

    if ((GREEN_CYC == 8'd0) || (YELLOW_CYC == 8'd0)) begin : g_cfg_chk
        $error("semaforo_side_chk: GREEN_CYC and YELLOW_CYC must be 1..255");
    end

    logic [2:0] prev_q;
    logic       changed;

    assign changed = prev_valid && (light != prev_q);

    assign enc_bad = !light_legal(light);
    assign non_red = light_legal(light) && (light != RED);
    assign seq_bad = changed && light_legal(prev_q) && light_legal(light)
                     && !step_legal(prev_q, light);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= light;
        end
    end

`ifdef SEMAFORO_DUR_CHECK_EN
    logic [7:0] run_q, run_d;
    logic       first_q, first_d;
    logic       yover_q, yover_d;

    always_comb begin
        run_d   = run_q;
        first_d = first_q;
        yover_d = yover_q;
        dur_bad = 1'b0;

        if (!prev_valid || changed) begin
            run_d = 8'd1;
        end else if (run_q != '1) begin
            run_d = run_q + 8'd1;
        end

        if (changed) begin
            first_d = 1'b0;
            yover_d = 1'b0;
        end

        // The run in progress at reset release is partial, so it is never judged.
        if (prev_valid && !first_q) begin
            if (changed && (prev_q == GREEN) && ((run_q == 8'd0) || (run_q > GREEN_CYC))) begin
                dur_bad = 1'b1;
            end
            if (changed && (prev_q == YELLOW) && (run_q != YELLOW_CYC)) begin
                dur_bad = 1'b1;
            end
            // Flag an overlong yellow once, on the sample that reaches YELLOW_CYC+1;
            // the sticky bit keeps a saturated counter from re-flagging.
            if (!changed && (prev_q == YELLOW) && (run_q == YELLOW_CYC) && !yover_q) begin
                dur_bad = 1'b1;
                yover_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q   <= '0;
            first_q <= 1'b1;
            yover_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            first_q <= first_d;
            yover_q <= yover_d;
        end
    end
`else
    assign dur_bad = 1'b0;
`endif

endmodule

// File: rtl/semaforo_monitor.sv
// Passive checker for the two-way traffic-light controller outputs: latches the first
// violation with a cycle stamp and counts violations and button presses.
// Define SEMAFORO_DUR_CHECK_EN to add green/yellow phase-duration checks (codes 5/6).
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter logic [7:0] GREEN_CYC  = GREEN_CYC_DEF,
    parameter logic [7:0] YELLOW_CYC = YELLOW_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bt,
    input  logic [2:0]  A,
    input  logic [2:0]  B,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] err_cycle,
    output logic [7:0]  viol_cnt,
    output logic [7:0]  bt_cnt
);

    logic a_enc, a_seq, a_dur, a_nonred;
    logic b_enc, b_seq, b_dur, b_nonred;

    logic        prev_valid_q;
    logic [15:0] cyc_q;
    logic        bt_prev_q;

    logic        err_q, err_d;
    err_code_e   err_code_q, err_code_d;
    logic [15:0] err_cycle_q, err_cycle_d;
    logic [7:0]  viol_cnt_q, viol_cnt_d;
    logic [7:0]  bt_cnt_q, bt_cnt_d;
    err_code_e   code_now;

    semaforo_side_chk #(
        .GREEN_CYC  (GREEN_CYC),
        .YELLOW_CYC (YELLOW_CYC)
    ) u_side_a (
        .clk        (clk),
        .rst        (rst),
        .light      (A),
        .prev_valid (prev_valid_q),
        .enc_bad    (a_enc),
        .seq_bad    (a_seq),
        .dur_bad    (a_dur),
        .non_red    (a_nonred)
    );

    semaforo_side_chk #(
        .GREEN_CYC  (GREEN_CYC),
        .YELLOW_CYC (YELLOW_CYC)
    ) u_side_b (
        .clk        (clk),
        .rst        (rst),
        .light      (B),
        .prev_valid (prev_valid_q),
        .enc_bad    (b_enc),
        .seq_bad    (b_seq),
        .dur_bad    (b_dur),
        .non_red    (b_nonred)
    );

    always_comb begin
        code_now = NONE;
        if (a_enc || b_enc) begin
            code_now = ENC;
        end else if (a_nonred && b_nonred) begin
            code_now = CONFLICT;
        end else if (a_seq) begin
            code_now = SEQ_A;
        end else if (b_seq) begin
            code_now = SEQ_B;
        end else if (a_dur) begin
            code_now = DUR_A;
        end else if (b_dur) begin
            code_now = DUR_B;
        end
    end

    always_comb begin
        err_d       = err_q;
        err_code_d  = err_code_q;
        err_cycle_d = err_cycle_q;
        viol_cnt_d  = viol_cnt_q;
        bt_cnt_d    = bt_cnt_q;

        if (code_now != NONE) begin
            if (!err_q) begin
                err_d       = 1'b1;
                err_code_d  = code_now;
                err_cycle_d = cyc_q;
            end
            if (viol_cnt_q != '1) begin
                viol_cnt_d = viol_cnt_q + 8'd1;
            end
        end

        if (bt && !bt_prev_q && (bt_cnt_q != '1)) begin
            bt_cnt_d = bt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_valid_q <= 1'b0;
            cyc_q        <= '0;
            bt_prev_q    <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= NONE;
            err_cycle_q  <= '0;
            viol_cnt_q   <= '0;
            bt_cnt_q     <= '0;
        end else begin
            prev_valid_q <= 1'b1;
            cyc_q        <= cyc_q + 16'd1;
            bt_prev_q    <= bt;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_cycle_q  <= err_cycle_d;
            viol_cnt_q   <= viol_cnt_d;
            bt_cnt_q     <= bt_cnt_d;
        end
    end

    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_cycle = err_cycle_q;
    assign viol_cnt  = viol_cnt_q;
    assign bt_cnt    = bt_cnt_q;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench for semaforo_monitor; duration scenarios run only when
// SEMAFORO_DUR_CHECK_EN is defined.
module tb_semaforo_monitor;

    localparam logic [7:0] GC = 8'd1;
    localparam logic [7:0] YC = 8'd3;
    localparam logic [2:0] LG = 3'b001;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LR = 3'b100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bt  = 1'b0;
    logic [2:0]  A   = LR;
    logic [2:0]  B   = LR;
    logic        err;
    logic [2:0]  err_code;
    logic [15:0] err_cycle;
    logic [7:0]  viol_cnt;
    logic [7:0]  bt_cnt;

    semaforo_monitor #(
        .GREEN_CYC  (GC),
        .YELLOW_CYC (YC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bt        (bt),
        .A         (A),
        .B         (B),
        .err       (err),
        .err_code  (err_code),
        .err_cycle (err_cycle),
        .viol_cnt  (viol_cnt),
        .bt_cnt    (bt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [2:0]  code;
        logic [15:0] cyc;
        logic [7:0]  viol;
        logic [7:0]  btc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    exp_t       m_e;
    bit         m_pv, m_btp;
    logic [2:0] m_pa, m_pb;
    int         m_cyc;
    int         m_ra, m_rb;
    bit         m_fa, m_fb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic bit lg(input logic [2:0] x);
        return (x == LG) || (x == LY) || (x == LR);
    endfunction

    function automatic bit fwd(input logic [2:0] p, input logic [2:0] c);
        return ((p == LG) && (c == LY)) || ((p == LY) && (c == LR)) || ((p == LR) && (c == LG));
    endfunction

    // Duration verdict for one side; run is an unbounded length of the current phase.
    task automatic side_dur(input logic [2:0] p, input logic [2:0] c, inout int run,
                            inout bit first, output bit bad);
        bad = 1'b0;
        if (m_pv && !first) begin
            if ((c != p) && (p == LG) && ((run < 1) || (run > int'(GC)))) bad = 1'b1;
            if ((c != p) && (p == LY) && (run != int'(YC)))               bad = 1'b1;
            if ((c == p) && (p == LY) && (run + 1 == int'(YC) + 1))       bad = 1'b1;
        end
        if (!m_pv || (c != p)) begin
            if (m_pv) first = 1'b0;
            run = 1;
        end else begin
            run = run + 1;
        end
    endtask

    task automatic model_reset();
        m_e   = '{1'b0, 3'd0, 16'd0, 8'd0, 8'd0};
        m_pv  = 1'b0;
        m_btp = 1'b0;
        m_pa  = 3'd0;
        m_pb  = 3'd0;
        m_cyc = 0;
        m_ra  = 0;
        m_rb  = 0;
        m_fa  = 1'b1;
        m_fb  = 1'b1;
    endtask

    task automatic model_step(input logic [2:0] a, input logic [2:0] b, input logic btv);
        logic [2:0] code;
        bit da, db;
        da = 1'b0;
        db = 1'b0;
`ifdef SEMAFORO_DUR_CHECK_EN
        side_dur(m_pa, a, m_ra, m_fa, da);
        side_dur(m_pb, b, m_rb, m_fb, db);
`endif
        code = 3'd0;
        if (!lg(a) || !lg(b))                                    code = 3'd1;
        else if ((a != LR) && (b != LR))                         code = 3'd2;
        else if (m_pv && lg(m_pa) && (a != m_pa) && !fwd(m_pa, a)) code = 3'd3;
        else if (m_pv && lg(m_pb) && (b != m_pb) && !fwd(m_pb, b)) code = 3'd4;
        else if (da)                                             code = 3'd5;
        else if (db)                                             code = 3'd6;
        if (code != 3'd0) begin
            if (!m_e.err) begin
                m_e.err  = 1'b1;
                m_e.code = code;
                m_e.cyc  = m_cyc[15:0];
            end
            if (m_e.viol != 8'd255) m_e.viol = m_e.viol + 8'd1;
        end
        if (btv && !m_btp && (m_e.btc != 8'd255)) m_e.btc = m_e.btc + 8'd1;
        m_btp = btv;
        m_cyc = m_cyc + 1;
        m_pv  = 1'b1;
        m_pa  = a;
        m_pb  = b;
        sb_q.push_back(m_e);
    endtask

    task automatic cyc(input logic [2:0] a, input logic [2:0] b, input logic btv);
        exp_t e;
        A  = a;
        B  = b;
        bt = btv;
        model_step(a, b, btv);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("err", {31'd0, err}, {31'd0, e.err});
            chk("err_code", {29'd0, err_code}, {29'd0, e.code});
            chk("err_cycle", {16'd0, err_cycle}, {16'd0, e.cyc});
            chk("viol_cnt", {24'd0, viol_cnt}, {24'd0, e.viol});
            chk("bt_cnt", {24'd0, bt_cnt}, {24'd0, e.btc});
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_code", {29'd0, err_code}, 32'd0);
        chk("rst_err_cycle", {16'd0, err_cycle}, 32'd0);
        chk("rst_viol_cnt", {24'd0, viol_cnt}, 32'd0);
        chk("rst_bt_cnt", {24'd0, bt_cnt}, 32'd0);
        model_reset();
        sb_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Legal two-way sequence, period 8: A G,Y,Y,Y,R,R,R,R; B R,R,R,R,G,Y,Y,Y.
    task automatic pat(input int k, output logic [2:0] a, output logic [2:0] b);
        int ph;
        ph = k % 8;
        a  = (ph == 0) ? LG : ((ph <= 3) ? LY : LR);
        b  = (ph <= 3) ? LR : ((ph == 4) ? LG : LY);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] a, b;
        int k;
        model_reset();
        #2;

        // legal sequence, 100 samples
        do_reset();
        for (int i = 0; i < 100; i++) begin
            pat(i, a, b);
            cyc(a, b, 1'b0);
        end
        chk("legal_err", {31'd0, err}, 32'd0);
        chk("legal_viol", {24'd0, viol_cnt}, 32'd0);

        // conflict at cycle 10
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pat(i, a, b);
            cyc(a, b, 1'b0);
        end
        cyc(LG, LY, 1'b0);
        chk("conf_err", {31'd0, err}, 32'd1);
        chk("conf_code", {29'd0, err_code}, 32'd2);
        chk("conf_cycle", {16'd0, err_cycle}, 32'd10);
        chk("conf_viol", {24'd0, viol_cnt}, 32'd1);
        for (int i = 11; i < 16; i++) begin
            pat(i, a, b);
            cyc(a, b, 1'b0);
        end

        // illegal encoding at cycle 5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pat(i, a, b);
            cyc(a, b, 1'b0);
        end
        cyc(3'b011, LG, 1'b0);
        chk("enc_code", {29'd0, err_code}, 32'd1);
        chk("enc_viol", {24'd0, viol_cnt}, 32'd1);

        // A jumps GREEN->RED at cycle 7
        do_reset();
        for (int i = 0; i < 7; i++) begin
            pat(i + 2, a, b);
            cyc(a, b, 1'b0);
        end
        cyc(LR, LR, 1'b0);
        chk("seq_code", {29'd0, err_code}, 32'd3);
        chk("seq_cycle", {16'd0, err_cycle}, 32'd7);

`ifdef SEMAFORO_DUR_CHECK_EN
        // B yellow only 2 samples, then red
        do_reset();
        for (int i = 0; i < 15; i++) begin
            pat(i, a, b);
            cyc(a, b, 1'b0);
        end
        cyc(LR, LR, 1'b0);
        chk("durb_code", {29'd0, err_code}, 32'd6);
        chk("durb_cycle", {16'd0, err_cycle}, 32'd15);

        // A yellow held into a 4th sample
        do_reset();
        for (int i = 0; i < 12; i++) begin
            pat(i, a, b);
            cyc(a, b, 1'b0);
        end
        cyc(LY, LR, 1'b0);
        chk("dura_code", {29'd0, err_code}, 32'd5);
        chk("dura_cycle", {16'd0, err_cycle}, 32'd12);
`endif

        // button edges with a reset in the middle
        do_reset();
        k = 0;
        for (int j = 0; j < 26; j++) begin
            if (j == 6) begin
                do_reset();
                k = 0;
            end else begin
                pat(k, a, b);
                if ((j == 4) || (j == 22)) a = 3'b000;
                cyc(a, b, ((j == 2) || (j == 8) || ((j >= 15) && (j <= 20))) ? 1'b1 : 1'b0);
                k++;
            end
        end
        chk("bt_final", {24'd0, bt_cnt}, 32'd2);
        chk("bt_err_cycle", {16'd0, err_cycle}, 32'd15);

        // bt held through reset counts once; saturation of both counters
        bt = 1'b1;
        do_reset();
        cyc(3'b000, LR, 1'b1);
        chk("bt_held", {24'd0, bt_cnt}, 32'd1);
        for (int i = 1; i < 560; i++) begin
            cyc(3'b000, LR, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        chk("sat_viol", {24'd0, viol_cnt}, 32'd255);
        chk("sat_bt", {24'd0, bt_cnt}, 32'd255);
        chk("sat_code", {29'd0, err_code}, 32'd1);
        chk("sat_cycle", {16'd0, err_cycle}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
